seg7_scan_ctrl: RTL and testbench
=================================

SEG7_SCAN_CTRL -- requirements
Module: seg7_scan_ctrl

Interface
REQ-001 Parameter NUM_DIGITS, default 4: number of multiplexed digits, legal 1..8.
REQ-002 Parameter SLOT_CYCLES, default 40000: clk cycles each digit is driven, legal >=1.
REQ-003 Parameter GAP_CYCLES, default 400: anti-ghost cycles with all digits off after each slot, legal >=0.
REQ-004 Parameter BLINK_FRAMES, default 250: frames per blink half-period, legal >=1.
REQ-005 Parameter ACTIVE_LOW, default 0: 1 inverts seg, dp and digit_sel at the pins.
REQ-006 clk  in  1  pixel-domain clock (40 MHz), all logic on rising edge.
REQ-007 clr  in  1  reset, asynchronous, active-high.
REQ-008 load  in  1  single-cycle strobe capturing value/dp_in into the shadow register.
REQ-009 value  in  4*NUM_DIGITS  hex nibbles; nibble k drives digit k; digit 0 is least significant.
REQ-010 dp_in  in  NUM_DIGITS  decimal point per digit, captured with value.
REQ-011 blank_mask  in  NUM_DIGITS  live, 1 = digit permanently dark.
REQ-012 blink_mask  in  NUM_DIGITS  live, 1 = digit dark during blink phase 1.
REQ-013 lz_en  in  1  live, leading-zero suppression enable.
REQ-014 seg  out  7  segments, seg[0]=A .. seg[6]=G, 1 = lit (before ACTIVE_LOW).
REQ-015 dp  out  1  decimal point of the driven digit.
REQ-016 digit_sel  out  NUM_DIGITS  one-hot digit enable during SHOW, all inactive during GAP.
REQ-017 frame_pulse  out  1  one-cycle pulse on the last cycle of each frame.
REQ-018 pending  out  1  high while a loaded value awaits commit.

Function
REQ-019 FSM states SHOW and GAP; SHOW lasts SLOT_CYCLES, then GAP lasts GAP_CYCLES (skipped when 0), then SHOW of next digit.
REQ-020 Digit index runs 0..NUM_DIGITS-1 and wraps to 0; one frame = NUM_DIGITS*(SLOT_CYCLES+GAP_CYCLES) cycles.
REQ-021 All outputs registered; digit_sel/seg/dp change on the same edge the FSM enters a state.
REQ-022 Hex decode 0-F standard: 0=0111111, 4=1100110, 8=1111111, A=1110111 (G..A).
REQ-023 Digit dark (seg=0, dp=0, digit_sel still asserted) if blank_mask[k], or blink_mask[k] with blink phase 1, or suppressed leading zero.
REQ-024 Leading zero: with lz_en, digits above the most significant nonzero nibble are dark; digit 0 is never suppressed.
REQ-025 load copies value/dp_in to shadow and sets pending; load while pending overwrites shadow (last wins).
REQ-026 Shadow commits to active register on the frame_pulse cycle, clearing pending; a load on that same cycle goes to shadow and commits at the following frame end, pending stays 1.
REQ-027 Blink phase toggles after every BLINK_FRAMES frame_pulses; starts at 0.
REQ-028 Mask or lz_en changes take effect at the next SHOW entry, never mid-slot.

Reset
REQ-029 While clr high: seg=0, dp=0, digit_sel all inactive, frame_pulse=0, pending=0, active and shadow=0, blink phase 0, counters 0, FSM SHOW digit 0 (outputs held off).
REQ-030 First rising edge after clr falls drives digit 0 SHOW; clr mid-frame aborts immediately and discards pending load.

Structure
REQ-031 Hex-to-7-segment table, segment bit-order constants and FSM state encoding live in shared package seg7_pkg.
REQ-032 Decoder is sub-module seg7_hex_decode (combinational, 4-bit in, 7-bit out), one instance.
REQ-033 Counter widths derived with $clog2 from parameters; no hard-coded widths.

Verification (NUM_DIGITS=4, SLOT_CYCLES=8, GAP_CYCLES=2, BLINK_FRAMES=2)
REQ-034 Scan: load 0x1234 in reset frame -> from next frame digit_sel=0001 8 cycles seg=1100110, 0000 2 cycles, then 0010 '3' ...; frame_pulse every 40 cycles.
REQ-035 Tearing: load 0xABCD during digit-1 SHOW -> pending=1, digits 1-3 still old this frame; frame_pulse commits, pending=0, next frame digit 0 shows D.
REQ-036 Leading zero: lz_en=1, value 0x0040 -> digits 3,2 dark, digit 1 '4', digit 0 '0'; value 0x0000 -> only digit 0 lit '0'.
REQ-037 Blink: blink_mask=0010 -> digit 1 lit frames 0-1, dark 2-3, lit 4-5; other digits unaffected.
REQ-038 Reset: clr pulsed during digit-2 SHOW with pending=1 -> outputs inactive same cycle, pending=0, digit 0 SHOW after release, active value 0.
REQ-039 ACTIVE_LOW=1: during GAP digit_sel=1111; digit '8' gives seg=0000000.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared definitions for the multiplexed 7-segment scanner: scan FSM encoding,
// segment bit positions and the hex-to-segment table.
package seg7_pkg;

  typedef enum logic {
    ST_SHOW = 1'b0,
    ST_GAP  = 1'b1
  } scan_state_t;

  localparam int SEG_N = 7;
  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;

  // Bit order G..A, 1 = segment lit.
  function automatic logic [SEG_N-1:0] hex_to_seg(input logic [3:0] hex);
    case (hex)
      4'h0:    hex_to_seg = 7'b0111111;
      4'h1:    hex_to_seg = 7'b0000110;
      4'h2:    hex_to_seg = 7'b1011011;
      4'h3:    hex_to_seg = 7'b1001111;
      4'h4:    hex_to_seg = 7'b1100110;
      4'h5:    hex_to_seg = 7'b1101101;
      4'h6:    hex_to_seg = 7'b1111101;
      4'h7:    hex_to_seg = 7'b0000111;
      4'h8:    hex_to_seg = 7'b1111111;
      4'h9:    hex_to_seg = 7'b1101111;
      4'hA:    hex_to_seg = 7'b1110111;
      4'hB:    hex_to_seg = 7'b1111100;
      4'hC:    hex_to_seg = 7'b0111001;
      4'hD:    hex_to_seg = 7'b1011110;
      4'hE:    hex_to_seg = 7'b1111001;
      default: hex_to_seg = 7'b1110001;
    endcase
  endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex nibble to 7-segment pattern (G..A, active-high).
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0]       hex,
  output logic [SEG_N-1:0] seg
);

  assign seg = hex_to_seg(hex);

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed 7-segment scanner with anti-ghost gaps, tear-free value
// updates at frame boundaries, blanking, blinking and leading-zero suppression.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int SLOT_CYCLES  = 40000,
  parameter int GAP_CYCLES   = 400,
  parameter int BLINK_FRAMES = 250,
  parameter int ACTIVE_LOW   = 0
) (
  input  logic                    clk,
  input  logic                    clr,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blank_mask,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  input  logic                    lz_en,
  output logic [SEG_N-1:0]        seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   digit_sel,
  output logic                    frame_pulse,
  output logic                    pending
);

  localparam int CNT_MAX = (SLOT_CYCLES > GAP_CYCLES) ? SLOT_CYCLES : GAP_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int BLK_W   = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic POL   = (ACTIVE_LOW != 0);

  localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(SLOT_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
  localparam logic [BLK_W-1:0] BLK_LAST  = BLK_W'(BLINK_FRAMES - 1);

  scan_state_t             state, state_n;
  logic [IDX_W-1:0]        idx, idx_n, idx_wrap;
  logic [CNT_W-1:0]        cnt, cnt_n;
  logic                    run;
  logic                    enter_show;
  logic                    frame_end_n;

  logic [4*NUM_DIGITS-1:0] active_val, shadow_val, val_eff;
  logic [NUM_DIGITS-1:0]   active_dp, shadow_dp, dp_eff;
  logic                    blink_phase, blink_eff;
  logic [BLK_W-1:0]        blink_cnt;

  logic [NUM_DIGITS-1:0]   lz_dark;
  logic                    upper_zero;
  logic [3:0]              nibble;
  logic [SEG_N-1:0]        seg_dec;
  logic                    dark;

  assign idx_wrap = (idx == IDX_LAST) ? '0 : idx + 1'b1;

  // run is low only on the first edge after reset, which enters digit 0 SHOW.
  always_comb begin
    state_n    = state;
    idx_n      = idx;
    cnt_n      = cnt + 1'b1;
    enter_show = 1'b0;
    if (!run) begin
      state_n    = ST_SHOW;
      idx_n      = '0;
      cnt_n      = '0;
      enter_show = 1'b1;
    end else begin
      case (state)
        ST_SHOW: begin
          if (cnt == SLOT_LAST) begin
            cnt_n = '0;
            if (GAP_CYCLES > 0) begin
              state_n = ST_GAP;
            end else begin
              idx_n      = idx_wrap;
              enter_show = 1'b1;
            end
          end
        end
        ST_GAP: begin
          if (cnt == GAP_LAST) begin
            cnt_n      = '0;
            state_n    = ST_SHOW;
            idx_n      = idx_wrap;
            enter_show = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign frame_end_n = (idx_n == IDX_LAST) &&
                       ((GAP_CYCLES > 0) ? (state_n == ST_GAP && cnt_n == GAP_LAST)
                                         : (state_n == ST_SHOW && cnt_n == SLOT_LAST));

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state <= ST_SHOW;
      idx   <= '0;
      cnt   <= '0;
      run   <= 1'b0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
      cnt   <= cnt_n;
      run   <= 1'b1;
    end
  end

  // The frame_pulse cycle's closing edge both commits and enters digit 0, so
  // the decode path must see the values being committed on that edge.
  assign val_eff   = (frame_pulse && pending) ? shadow_val : active_val;
  assign dp_eff    = (frame_pulse && pending) ? shadow_dp  : active_dp;
  assign blink_eff = (frame_pulse && blink_cnt == BLK_LAST) ? ~blink_phase : blink_phase;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      active_val  <= '0;
      active_dp   <= '0;
      shadow_val  <= '0;
      shadow_dp   <= '0;
      pending     <= 1'b0;
      blink_phase <= 1'b0;
      blink_cnt   <= '0;
    end else begin
      if (frame_pulse && pending) begin
        active_val <= shadow_val;
        active_dp  <= shadow_dp;
        pending    <= 1'b0;
      end
      if (load) begin
        shadow_val <= value;
        shadow_dp  <= dp_in;
        pending    <= 1'b1;
      end
      if (frame_pulse) begin
        if (blink_cnt == BLK_LAST) begin
          blink_cnt   <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          blink_cnt <= blink_cnt + 1'b1;
        end
      end
    end
  end

  // A digit is a suppressed leading zero when it and every digit above are 0.
  always_comb begin
    upper_zero = 1'b1;
    lz_dark    = '0;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      upper_zero = upper_zero && (val_eff[4*k +: 4] == 4'h0);
      lz_dark[k] = upper_zero;
    end
  end

  assign nibble = val_eff[4*idx_n +: 4];
  assign dark   = blank_mask[idx_n] | (blink_mask[idx_n] & blink_eff) | (lz_en & lz_dark[idx_n]);

  seg7_hex_decode u_decode (
    .hex (nibble),
    .seg (seg_dec)
  );

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      seg         <= {SEG_N{POL}};
      dp          <= POL;
      digit_sel   <= {NUM_DIGITS{POL}};
      frame_pulse <= 1'b0;
    end else begin
      frame_pulse <= frame_end_n;
      if (enter_show) begin
        digit_sel <= (NUM_DIGITS'(1) << idx_n) ^ {NUM_DIGITS{POL}};
        seg       <= (dark ? '0 : seg_dec) ^ {SEG_N{POL}};
        dp        <= (~dark & dp_eff[idx_n]) ^ POL;
      end else if (state_n == ST_GAP) begin
        digit_sel <= {NUM_DIGITS{POL}};
        seg       <= {SEG_N{POL}};
        dp        <= POL;
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Randomised scoreboard bench for seg7_scan_ctrl: an active-high and an
// active-low instance are compared every cycle against a frame/slot model.
module tb_seg7_scan_ctrl;

  localparam int N  = 4;
  localparam int S  = 8;
  localparam int G  = 2;
  localparam int B  = 2;
  localparam int FL = N * (S + G);

  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic        load = 1'b0;
  logic [15:0] value = '0;
  logic [3:0]  dp_in = '0, blank_mask = '0, blink_mask = '0;
  logic        lz_en = 1'b0;

  logic [6:0]  seg_a, seg_b;
  logic        dp_a, dp_b, fp_a, fp_b, pend_a, pend_b;
  logic [3:0]  sel_a, sel_b;

  seg7_scan_ctrl #(.NUM_DIGITS(N), .SLOT_CYCLES(S), .GAP_CYCLES(G),
                   .BLINK_FRAMES(B), .ACTIVE_LOW(0)) dut_hi (
    .clk(clk), .clr(clr), .load(load), .value(value), .dp_in(dp_in),
    .blank_mask(blank_mask), .blink_mask(blink_mask), .lz_en(lz_en),
    .seg(seg_a), .dp(dp_a), .digit_sel(sel_a), .frame_pulse(fp_a), .pending(pend_a));

  seg7_scan_ctrl #(.NUM_DIGITS(N), .SLOT_CYCLES(S), .GAP_CYCLES(G),
                   .BLINK_FRAMES(B), .ACTIVE_LOW(1)) dut_lo (
    .clk(clk), .clr(clr), .load(load), .value(value), .dp_in(dp_in),
    .blank_mask(blank_mask), .blink_mask(blink_mask), .lz_en(lz_en),
    .seg(seg_b), .dp(dp_b), .digit_sel(sel_b), .frame_pulse(fp_b), .pending(pend_b));

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] sel;
    logic [6:0] seg;
    logic       dp;
    logic       fp;
    logic       pend;
  } exp_t;

  localparam exp_t OFF = '{sel: 4'h0, seg: 7'h00, dp: 1'b0, fp: 1'b0, pend: 1'b0};

  exp_t q[$];
  exp_t m;
  int   checks = 0;
  int   passed = 0;
  int   cyc = 0;

  logic [6:0] hex_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  // Model: t counts cycles since the first edge after reset release.
  int          t;
  logic [15:0] act_v, sh_v;
  logic [3:0]  act_dp, sh_dp;
  logic        pend_m;
  logic [6:0]  slot_seg;
  logic        slot_dp;

  task automatic model_reset();
    t = 0; act_v = '0; sh_v = '0; act_dp = '0; sh_dp = '0; pend_m = 1'b0;
    slot_seg = '0; slot_dp = 1'b0;
  endtask

  task automatic model_edge(output exp_t e);
    int f, pos, d, w;
    logic dark;
    logic [15:0] upper;
    logic [3:0] nib;
    f = t / FL; pos = t % FL; d = pos / (S + G); w = pos % (S + G);
    if (pos == 0 && t > 0 && pend_m) begin
      act_v = sh_v; act_dp = sh_dp; pend_m = 1'b0;
    end
    if (load) begin
      sh_v = value; sh_dp = dp_in; pend_m = 1'b1;
    end
    if (w == 0) begin
      upper = act_v >> (4 * d);
      nib   = upper[3:0];
      dark  = blank_mask[d] || (blink_mask[d] && ((f / B) % 2 == 1)) ||
              (lz_en && d > 0 && upper == 16'h0);
      slot_seg = dark ? 7'h00 : hex_tab[nib];
      slot_dp  = !dark && act_dp[d];
    end
    e.sel  = (w < S) ? 4'(1 << d) : 4'h0;
    e.seg  = (w < S) ? slot_seg : 7'h00;
    e.dp   = (w < S) ? slot_dp : 1'b0;
    e.fp   = (pos == FL - 1);
    e.pend = pend_m;
    t++;
  endtask

  function automatic logic [15:0] pick_value();
    case ($urandom_range(0, 5))
      0:       pick_value = 16'h0040;
      1:       pick_value = 16'h0000;
      2:       pick_value = 16'($urandom) & 16'h00FF;
      3:       pick_value = 16'($urandom) & 16'h0F0F;
      default: pick_value = 16'($urandom);
    endcase
  endfunction

  always @(negedge clk) begin
    if (q.size() > 0) begin
      m = q.pop_front();
      checks++;
      if ({sel_a, seg_a, dp_a, fp_a, pend_a} === m) passed++;
      else $display("FAIL active_high cyc=%0d got sel=%b seg=%b dp=%b fp=%b pend=%b need sel=%b seg=%b dp=%b fp=%b pend=%b",
                    cyc, sel_a, seg_a, dp_a, fp_a, pend_a, m.sel, m.seg, m.dp, m.fp, m.pend);
      checks++;
      if ({sel_b, seg_b, dp_b, fp_b, pend_b} === {~m.sel, ~m.seg, ~m.dp, m.fp, m.pend}) passed++;
      else $display("FAIL active_low cyc=%0d got sel=%b seg=%b dp=%b fp=%b pend=%b need sel=%b seg=%b dp=%b fp=%b pend=%b",
                    cyc, sel_b, seg_b, dp_b, fp_b, pend_b, ~m.sel, ~m.seg, ~m.dp, m.fp, m.pend);
    end
  end

  initial begin
    exp_t e;
    int   rst_left;
    bit   did_mid_reset;
    int   f, pos;
    rst_left = 3;
    did_mid_reset = 1'b0;
    model_reset();
    clr = 1'b1;
    for (int c = 0; c < 60 * FL; c++) begin
      @(posedge clk);
      #1;
      cyc = c;
      f = t / FL; pos = t % FL;
      if (rst_left == 0 && !did_mid_reset && f >= 25 && pos == 2 * (S + G) + 3 && pend_m) begin
        clr = 1'b1;
        rst_left = 3;
        did_mid_reset = 1'b1;
      end
      if (rst_left > 0) begin
        q.push_back(OFF);
        rst_left--;
        load = 1'b0; blank_mask = '0; blink_mask = '0; lz_en = 1'b0;
        if (rst_left == 0) begin
          clr = 1'b0;
          model_reset();
        end
        continue;
      end
      model_edge(e);
      q.push_back(e);
      // t now names the cycle whose opening edge samples these inputs.
      f = t / FL; pos = t % FL;
      if (c < 6 * FL) begin
        load = (t == 2);
        value = 16'h1234; dp_in = 4'b0100;
      end else if (f == 25 && pos == (S + G) + 2) begin
        load = 1'b1; value = 16'hABCD; dp_in = 4'b0001;
      end else begin
        load = ($urandom_range(0, 29) == 0) || (pos == 0 && f % 4 == 2);
        if (load) begin
          value = pick_value();
          dp_in = 4'($urandom);
        end
        if ($urandom_range(0, 15) == 0)
          blank_mask = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
        if ($urandom_range(0, 15) == 0)
          blink_mask = 4'($urandom);
        if ($urandom_range(0, 15) == 0)
          lz_en = 1'($urandom);
      end
    end
    @(negedge clk);
    #1;
    checks++;
    if (q.size() == 0 && did_mid_reset) passed++;
    else $display("FAIL drain got queued=%0d mid_reset=%0d need queued=0 mid_reset=1",
                  q.size(), did_mid_reset);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
